ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 24 ++
 rtl/ram_arbiter.sv | 112 +++++++++++
 tb/tb_ram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle for ram_arbiter: one request channel plus its completion response.
// The arbiter takes the slave modport; a requester drives the master modport.
interface ram_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12
);
  logic                     valid;
  logic                     wen;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     ready;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;

  modport master (
    output valid, wen, addr, wdata,
    input  ready, resp_valid, resp_rdata
  );

  modport slave (
    input  valid, wen, addr, wdata,
    output ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each transaction takes IDLE/RESP -> ACCESS -> RESP; a new one may be accepted in RESP.
module ram_arbiter #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  ram_arbiter_if.slave             req0_io,
  ram_arbiter_if.slave             req1_io,
  output logic                     ram_wen_o,
  output logic [ADDRESS_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0]    ram_data_in_o,
  input  logic [DATA_WIDTH-1:0]    ram_data_out_i
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                   state_q, state_d;
  logic                     last_grant_q, last_grant_d;
  logic                     owner_q, owner_d;
  logic                     op_q, op_d;
  logic                     ram_wen_q, ram_wen_d;
  logic [ADDRESS_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0]    ram_data_in_q, ram_data_in_d;

  logic                     accept;
  logic                     winner;
  logic                     win_wen;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]    win_wdata;
  logic                     resp_active;
  logic [DATA_WIDTH-1:0]    resp_data;

  // Grant: ready is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    if (req0_io.valid && req1_io.valid) begin
      winner = ~last_grant_q;
    end else begin
      winner = req1_io.valid;
    end
    accept = ~rst && (state_q == StIdle || state_q == StResp) &&
             (req0_io.valid || req1_io.valid);
    req0_io.ready = accept && !winner;
    req1_io.ready = accept && winner;
    win_wen   = winner ? req1_io.wen   : req0_io.wen;
    win_addr  = winner ? req1_io.addr  : req0_io.addr;
    win_wdata = winner ? req1_io.wdata : req0_io.wdata;
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    op_d          = op_q;
    ram_wen_d     = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          state_d       = StAccess;
          last_grant_d  = winner;
          owner_d       = winner;
          op_d          = win_wen;
          ram_wen_d     = win_wen;
          ram_addr_d    = win_addr;
          ram_data_in_d = win_wdata;
        end else begin
          state_d = StIdle;
        end
      end
      StAccess: state_d = StResp;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      op_q          <= 1'b0;
      ram_wen_q     <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      op_q          <= op_d;
      ram_wen_q     <= ram_wen_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  // RESP: the RAM read port already holds the word latched at the end of ACCESS.
  always_comb begin
    resp_active           = ~rst && (state_q == StResp);
    resp_data             = op_q ? '0 : ram_data_out_i;
    req0_io.resp_valid    = resp_active && !owner_q;
    req1_io.resp_valid    = resp_active && owner_q;
    req0_io.resp_rdata    = (resp_active && !owner_q) ? resp_data : '0;
    req1_io.resp_rdata    = (resp_active && owner_q) ? resp_data : '0;
  end

  assign ram_wen_o     = ram_wen_q;
  assign ram_addr_o    = ram_addr_q;
  assign ram_data_in_o = ram_data_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: cycle model + response scoreboard, a vector table,
// and directed sequences for contention, held requests, reset mid-write and idle.
module tb_ram_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) req0_if ();
  ram_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) req1_if ();

  logic          ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  ram_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req0_io        (req0_if),
    .req1_io        (req1_if),
    .ram_wen_o      (ram_wen),
    .ram_addr_o     (ram_addr),
    .ram_data_in_o  (ram_din),
    .ram_data_out_i (ram_dout)
  );

  // Synchronous RAM and the bench's own expected-content copy.
  logic [DW-1:0] mem    [0:4095];
  logic [DW-1:0] shadow [0:4095];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 16) ? 32'hDEADBEEF : (32'hA5A50000 ^ a);
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t          sb_q[$];
  int            m_state;  // 0 idle, 1 access, 2 resp
  logic          m_last, m_owner, m_op;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            resp_cnt0 = 0;
  int            resp_cnt1 = 0;
  int            ready_cnt = 0;
  int            wen_cycles = 0;

  // Cycle-level reference model, evaluated mid-cycle with inputs stable.
  always @(negedge clk) begin
    logic e_acc, e_win;
    exp_t e;
    if (req0_if.resp_valid === 1'b1) resp_cnt0++;
    if (req1_if.resp_valid === 1'b1) resp_cnt1++;
    if (req0_if.ready === 1'b1 || req1_if.ready === 1'b1) ready_cnt++;
    if (ram_wen === 1'b1) wen_cycles++;
    if (rst) begin
      chk("rst_ready0", req0_if.ready, 0);
      chk("rst_ready1", req1_if.ready, 0);
      chk("rst_resp0_valid", req0_if.resp_valid, 0);
      chk("rst_resp1_valid", req1_if.resp_valid, 0);
      chk("rst_resp0_rdata", req0_if.resp_rdata, 0);
      chk("rst_resp1_rdata", req1_if.resp_rdata, 0);
      chk("rst_ram_wen", ram_wen, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_din", ram_din, 0);
      m_state = 0;
      m_last  = 1'b1;
      m_owner = 1'b0;
      m_op    = 1'b0;
      sb_q.delete();
    end else begin
      e_acc = (m_state != 1) && (req0_if.valid || req1_if.valid);
      e_win = (req0_if.valid && req1_if.valid) ? ~m_last : req1_if.valid;
      chk("ready0", req0_if.ready, e_acc && !e_win);
      chk("ready1", req1_if.ready, e_acc && e_win);
      chk("ram_wen", ram_wen, (m_state == 1) && m_op);
      if (m_state == 1) begin
        chk("access_addr", ram_addr, m_addr);
        chk("access_din", ram_din, m_wdata);
      end
      if (m_state == 2) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got empty queue expected a pending response");
        end else begin
          e = sb_q.pop_front();
          chk("resp0_valid", req0_if.resp_valid, !e.owner);
          chk("resp1_valid", req1_if.resp_valid, e.owner);
          chk("resp0_rdata", req0_if.resp_rdata, e.owner ? '0 : e.rdata);
          chk("resp1_rdata", req1_if.resp_rdata, e.owner ? e.rdata : '0);
        end
      end else begin
        chk("no_resp0", req0_if.resp_valid, 0);
        chk("no_resp1", req1_if.resp_valid, 0);
      end
      if (m_state == 1) begin
        if (m_op) shadow[m_addr] = m_wdata;
        m_state = 2;
      end else if (e_acc) begin
        m_state = 1;
        m_last  = e_win;
        m_owner = e_win;
        m_op    = e_win ? req1_if.wen   : req0_if.wen;
        m_addr  = e_win ? req1_if.addr  : req0_if.addr;
        m_wdata = e_win ? req1_if.wdata : req0_if.wdata;
        e.owner = e_win;
        e.rdata = m_op ? '0 : shadow[m_addr];
        sb_q.push_back(e);
      end else begin
        m_state = 0;
      end
    end
  end

  task automatic drive(input logic sel, input logic v, input logic wen,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (sel) begin
      req1_if.valid = v; req1_if.wen = wen; req1_if.addr = addr; req1_if.wdata = wdata;
    end else begin
      req0_if.valid = v; req0_if.wen = wen; req0_if.addr = addr; req0_if.wdata = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction: bounded wait for ready, then for the response pulse.
  task automatic do_txn(input string name, input logic sel, input logic wen,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rdata);
    bit            got;
    int            lat;
    int            wen_base;
    logic [DW-1:0] rd;
    wen_base = wen_cycles;
    drive(sel, 1'b1, wen, addr, wdata);
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((sel ? req1_if.ready : req0_if.ready) === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk({name, "_accept"}, got, 1);
    tick();
    drive(sel, 1'b0, 1'b0, '0, '0);
    got = 0;
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((sel ? req1_if.resp_valid : req0_if.resp_valid) === 1'b1) begin
        got = 1;
        lat = i;
        rd  = sel ? req1_if.resp_rdata : req0_if.resp_rdata;
        break;
      end
    end
    chk({name, "_resp_seen"}, got, 1);
    chk({name, "_latency"}, lat, 1);
    chk({name, "_rdata"}, rd, exp_rdata);
    tick();
    chk({name, "_wen_cycles"}, wen_cycles - wen_base, {31'b0, wen});
  endtask

  typedef struct {
    string         name;
    logic          sel;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int order[$];
    int times[$];
    int b0, b1, br, bw;
    vecs[0] = '{"rd0_010",   1'b0, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF};
    vecs[1] = '{"wr1_020",   1'b1, 1'b1, 12'h020, 32'h55AA00FF, 32'h0};
    vecs[2] = '{"rd1_020",   1'b1, 1'b0, 12'h020, 32'h0,        32'h55AA00FF};
    vecs[3] = '{"wr0_7ff",   1'b0, 1'b1, 12'h7FF, 32'h0BADF00D, 32'h0};
    vecs[4] = '{"rd1_7ff",   1'b1, 1'b0, 12'h7FF, 32'h0,        32'h0BADF00D};
    vecs[5] = '{"rd0_fff",   1'b0, 1'b0, 12'hFFF, 32'h0,        32'hA5A50FFF};
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = init_val(i);
      shadow[i] = init_val(i);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    foreach (vecs[i]) do_txn(vecs[i].name, vecs[i].sel, vecs[i].wen, vecs[i].addr,
                             vecs[i].wdata, vecs[i].exp_rdata);

    // Contention straight after reset: 0,1,0,1 at two-cycle spacing.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 12'h100, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 12'h101, 32'h0);
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      @(negedge clk);
      if (req0_if.ready === 1'b1) begin order.push_back(0); times.push_back(i); end
      if (req1_if.ready === 1'b1) begin order.push_back(1); times.push_back(i); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    chk("contend_grants", order.size(), 4);
    foreach (order[k]) begin
      chk($sformatf("contend_order%0d", k), order[k], k % 2);
      if (k > 0) chk($sformatf("contend_gap%0d", k), times[k] - times[k-1], 2);
    end
    repeat (4) tick();

    // Request from 1 arrives while 0 is in ACCESS.
    b1 = resp_cnt1;
    drive(1'b0, 1'b1, 1'b0, 12'h010, 32'h0);
    @(negedge clk);
    chk("held_ready0", req0_if.ready, 1);
    tick();
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b1, 1'b0, 12'h020, 32'h1111);
    @(negedge clk);
    chk("held_access_ready1", req1_if.ready, 0);
    tick();
    @(negedge clk);
    chk("held_resp_ready1", req1_if.ready, 1);
    tick();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("held_addr", ram_addr, 12'h020);
    repeat (4) tick();
    chk("held_one_resp1", resp_cnt1 - b1, 1);

    // Reset during ACCESS of a write.
    drive(1'b0, 1'b1, 1'b1, 12'h030, 32'h12345678);
    @(negedge clk);
    chk("rstw_ready0", req0_if.ready, 1);
    @(posedge clk);
    #2;
    b0  = resp_cnt0;
    b1  = resp_cnt1;
    chk("rstw_wen_before", ram_wen, 1);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    chk("rstw_wen_async", ram_wen, 0);
    chk("rstw_addr_async", ram_addr, 0);
    repeat (2) tick();
    chk("rstw_mem_kept", mem[12'h030], init_val(12'h030));
    rst = 1'b0;
    repeat (3) tick();
    chk("rstw_no_resp0", resp_cnt0 - b0, 0);
    chk("rstw_no_resp1", resp_cnt1 - b1, 0);

    // Idle window.
    b0 = resp_cnt0; b1 = resp_cnt1; br = ready_cnt; bw = wen_cycles;
    repeat (10) tick();
    chk("idle_ready", ready_cnt - br, 0);
    chk("idle_resp", (resp_cnt0 - b0) + (resp_cnt1 - b1), 0);
    chk("idle_wen", wen_cycles - bw, 0);
    chk("idle_ram_wen", ram_wen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
